univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register: successor to the fixed 16-bit load/serial-in shift register.
- Adds selectable mode (load, shift, rotate, arithmetic shift), a single-step path and a multi-cycle burst engine.
- The burst engine performs N shifts and then signals done.
- Used as a datapath building block for serialisers and bit-manipulation units.

Parameters:
- WIDTH, 16, register width in bits (>= 2).
- CNT_W, 5, width of burst count; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  parallel load data.
- din  input  1  serial input bit for SHL/SHR.
- mode  input  3  operation select, encodings below.
- en  input  1  single-step enable, honoured in IDLE only.
- start  input  1  begin burst of count operations using mode.
- count  input  CNT_W  number of burst operations.
- q  output  WIDTH  register contents.
- sout  output  1  bit leaving the register this cycle.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- parity  output  1  even parity of q (optional feature).

Behaviour:
- Reset: rst=1 forces, asynchronously, q=0, busy=0, done=0, state=IDLE, remaining=0, latched mode=HOLD. This applies mid-burst as well; the aborted burst produces no done pulse.
- Mode encodings:
  - 0 HOLD
  - 1 LOAD: q<=d
  - 2 SHL: q<={q[W-2:0],din}
  - 3 SHR: q<={din,q[W-1:1]}
  - 4 ROL: q<={q[W-2:0],q[W-1]}
  - 5 ROR: q<={q[0],q[W-1:1]}
  - 6 ASR: q<={q[W-1],q[W-1:1]}
  - 7 reserved, behaves as HOLD.
- sout is combinational from the effective mode: q[W-1] for SHL/ROL, q[0] for SHR/ROR/ASR, 0 for HOLD/LOAD/reserved.
- Effective mode is the input mode in IDLE and the latched mode in BUSY.
- IDLE state:
  - start=1 has priority over en.
  - start with count>0: latch mode and count, busy<=1, go to BUSY. q is not modified on this edge.
  - start with count=0: no operation; done<=1 for one cycle; stay IDLE.
  - start=0 and en=1: apply mode once on this edge.
  - start=0 and en=0: q holds.
- BUSY state:
  - Each edge applies the latched mode once and decrements remaining.
  - On the edge where remaining goes 1->0: busy<=0, done<=1, go to IDLE.
  - In BUSY, start, en, mode, count and d are ignored.
- Latency: burst of N starts on edge E0 and performs its shifts on edges E1..EN. busy is high from E0 to EN; done is high from EN to EN+1.
- done is registered and never high for more than one cycle. A new start may be accepted on the same edge that done is high.
- LOAD with start and count=N reloads d N times; the result equals a single load.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined: parity = XOR-reduce of q, combinational, updates with q.
- Undefined: parity tied to 0 and no parity logic is synthesised.
- All other behaviour is identical in both builds.

Decomposition:
- Package usr_pkg holds the mode encoding constants (MODE_HOLD..MODE_ASR) and the state encodings (ST_IDLE, ST_BUSY).
- One combinational sub-module, usr_step, computes next q and sout from (q, mode, din).
- The top level holds the state register, counter, latched mode, and busy/done registers.

Test Plan:
- rst=1 with q at 16'h1234 -> q=0, busy=0, done=0 immediately, before any clk edge.
- en=1, mode=LOAD, d=16'h1234 -> q=16'h1234 after one edge. Then mode=SHL, din=1, one edge -> q=16'h2469 with sout=0 before that edge.
- From q=16'h1234: start=1, mode=ROR, count=4 -> busy high 4 cycles after the start edge, q=16'h4123 on the 4th shift edge, done high exactly one cycle; en pulses during the burst have no effect.
- From q=16'h8000: start, mode=ASR, count=3 -> q=16'hF000 at done. Then start, mode=SHR, din=0, count=16 -> q=16'h0000.
- start with count=0 -> done pulses next cycle, busy stays 0, q unchanged.
- rst asserted after 2 shifts of a count=8 SHL burst -> q=0, busy=0 asynchronously, no done pulse; after rst release, the next start is accepted normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// burst-engine states.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/usr_step.sv
// One combinational step of the universal shift register: next contents and
// the bit leaving the register for a given mode.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic [2:0]       i_mode,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q_nxt,
    output logic             o_sout
);

    logic signed [WIDTH-1:0] w_q_s;

    assign w_q_s = $signed(i_q);

    always_comb begin
        o_q_nxt = i_q;
        o_sout  = 1'b0;
        case (i_mode)
            MODE_LOAD: o_q_nxt = i_d;
            MODE_SHL: begin
                o_q_nxt = {i_q[WIDTH-2:0], i_din};
                o_sout  = i_q[WIDTH-1];
            end
            MODE_SHR: begin
                o_q_nxt = {i_din, i_q[WIDTH-1:1]};
                o_sout  = i_q[0];
            end
            MODE_ROL: begin
                o_q_nxt = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_sout  = i_q[WIDTH-1];
            end
            MODE_ROR: begin
                o_q_nxt = {i_q[0], i_q[WIDTH-1:1]};
                o_sout  = i_q[0];
            end
            MODE_ASR: begin
                o_q_nxt = $unsigned(w_q_s >>> 1);
                o_sout  = i_q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and N-operation burst engine.
// Optional even-parity output enabled by defining USR_PARITY_EN.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             din,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_rem;
    logic [2:0]       r_mode;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_mode;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout;

    // During a burst the operation and load data are frozen at start time
    assign w_mode = (r_state == ST_BUSY) ? r_mode : mode;
    assign w_d    = (r_state == ST_BUSY) ? r_d    : d;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q     (r_q),
        .i_d     (w_d),
        .i_mode  (w_mode),
        .i_din   (din),
        .o_q_nxt (w_q_nxt),
        .o_sout  (w_sout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '0;
            r_d     <= '0;
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_mode  <= MODE_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_mode  <= mode;
                            r_d     <= d;
                            r_rem   <= count;
                            r_busy  <= 1'b1;
                            r_state <= ST_BUSY;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else if (en) begin
                        r_q <= w_q_nxt;
                    end
                end
                ST_BUSY: begin
                    r_q   <= w_q_nxt;
                    r_rem <= r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign q    = r_q;
    assign sout = w_sout;
    assign busy = r_busy;
    assign done = r_done;

`ifdef USR_PARITY_EN
    assign parity = ^r_q;
`else
    assign parity = 1'b0;
`endif

endmodule
